// File: rtl/apb_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_scan_if
//  Purpose  : APB bus bundle between the upstream I2C->APB bridge (master)
//             and the scan-chain controller (slave).
//  Signals  : psel, penable, pwrite, paddr[PADDR_WL], pwdata[PDATA_WL]
//             (master -> slave); prdata[PDATA_WL], pready (slave -> master)
//  Modports : master, slave
//  Revision : 1.0  initial release
// ============================================================================
interface apb_scan_if #(
    parameter int PADDR_WL = 8,
    parameter int PDATA_WL = 8
);
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [PADDR_WL-1:0] paddr;
    logic [PDATA_WL-1:0] pwdata;
    logic [PDATA_WL-1:0] prdata;
    logic                pready;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready
    );
endinterface
`default_nettype wire

// File: rtl/apb_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : apb_scan_ctrl
//  Purpose  : APB-slave scan-chain controller. A host loads a shift buffer,
//             chain length and phase divider, then writes START. The block
//             optionally pulses a capture strobe, shifts the buffer out LSB
//             first on scan_out while capturing scan_in into the top of the
//             active window, and optionally pulses an update strobe.
//  Ports    : clk           system clock (rising edge)
//             reset_b       synchronous active-low reset
//             apb           APB slave bundle (apb_scan_if.slave)
//             scan_clk      scan chain clock
//             scan_enable   high during the shift phase
//             scan_out      serial data to the chain (registered)
//             scan_in       serial data from the chain
//             scan_capture  capture strobe
//             scan_update   update strobe
//  Options  : SCAN_STROBE_EN  when defined, the CAPT/UPD states, the strobe
//             outputs and the CTRL CAP/UPD bits exist; otherwise the strobes
//             are tied low and CAP/UPD read 0.
//  Map      : 0x00 CTRL, 0x01 STATUS, 0x02 LEN, 0x03 DIV, 0x10+i DATA[i]
//  Revision : 1.0  initial release
// ============================================================================
module apb_scan_ctrl #(
    parameter int PADDR_WL  = 8,
    parameter int PDATA_WL  = 8,
    parameter int BUF_BYTES = 4
) (
    input  logic      clk,
    input  logic      reset_b,
    apb_scan_if.slave apb,
    output logic      scan_clk,
    output logic      scan_enable,
    output logic      scan_out,
    input  logic      scan_in,
    output logic      scan_capture,
    output logic      scan_update
);

    localparam int c_BUF_BITS  = BUF_BYTES * 8;
    localparam int c_BCW       = $clog2(c_BUF_BITS + 1);
    localparam int c_DATA_BASE = 16;

    localparam logic [PADDR_WL-1:0] c_ADDR_CTRL = PADDR_WL'(0);
    localparam logic [PADDR_WL-1:0] c_ADDR_STAT = PADDR_WL'(1);
    localparam logic [PADDR_WL-1:0] c_ADDR_LEN  = PADDR_WL'(2);
    localparam logic [PADDR_WL-1:0] c_ADDR_DIV  = PADDR_WL'(3);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CAPT = 3'd1,
        S_LO   = 3'd2,
        S_HI   = 3'd3,
        S_UPD  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic                    r_capt_hi;     // second half of CAPT (scan_clk high)
    logic [7:0]              r_div_cnt;
    logic [c_BCW-1:0]        r_bit_cnt;
    logic                    r_scan_clk;
    logic                    r_scan_en;
    logic                    r_scan_out;
    logic                    r_scan_cap;
    logic                    r_scan_upd;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic [7:0]              r_len;
    logic [7:0]              r_div;
    logic [c_BUF_BITS-1:0]   r_buf;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t                  w_state_nxt;
    logic                    w_capt_hi_nxt;
    logic [7:0]              w_div_cnt_nxt;
    logic [c_BCW-1:0]        w_bit_cnt_nxt;
    logic                    w_scan_clk_nxt;
    logic                    w_scan_en_nxt;
    logic                    w_scan_cap_nxt;
    logic                    w_scan_upd_nxt;
    logic                    w_load_out;
    logic                    w_shift;
    logic                    w_run_end;
    logic                    w_phase_last;
    logic                    w_last_bit;
    logic                    w_wr;
    logic                    w_wr_ctrl;
    logic                    w_wr_stat;
    logic                    w_wr_len;
    logic                    w_wr_div;
    logic [BUF_BYTES-1:0]    w_data_hit;
    logic                    w_len_ok;
    logic                    w_start_req;
    logic                    w_start_ok;
    logic                    w_start_err;
    logic                    w_cap_bit;
    logic                    w_upd_bit;
    logic                    w_cap_go;
    logic [c_BUF_BITS-1:0]   w_buf_rsh;
    logic [c_BUF_BITS-1:0]   w_buf_shift;
    logic [PDATA_WL-1:0]     w_rdata;

    // ------------------------------------------------------------------
    // APB decode
    // ------------------------------------------------------------------
    assign w_wr      = apb.psel & apb.penable & apb.pwrite;
    assign w_wr_ctrl = w_wr && (apb.paddr == c_ADDR_CTRL);
    assign w_wr_stat = w_wr && (apb.paddr == c_ADDR_STAT);
    assign w_wr_len  = w_wr && (apb.paddr == c_ADDR_LEN);
    assign w_wr_div  = w_wr && (apb.paddr == c_ADDR_DIV);

    for (genvar gi = 0; gi < BUF_BYTES; gi++) begin : g_data_hit
        assign w_data_hit[gi] = (apb.paddr == PADDR_WL'(c_DATA_BASE + gi));
    end

    assign w_len_ok    = (r_len != 8'd0) && (int'(r_len) <= c_BUF_BITS);
    // START while a run is active is dropped silently (no ERR).
    assign w_start_req = w_wr_ctrl && apb.pwdata[0] && !r_busy;
    assign w_start_ok  = w_start_req && w_len_ok;
    assign w_start_err = w_start_req && !w_len_ok;

    // ------------------------------------------------------------------
    // Optional capture/update strobe configuration bits
    // ------------------------------------------------------------------
`ifdef SCAN_STROBE_EN
    logic r_cap;
    logic r_upd;

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_cap <= 1'b0;
            r_upd <= 1'b0;
        end else if (w_wr_ctrl && !r_busy) begin
            r_cap <= apb.pwdata[1];
            r_upd <= apb.pwdata[2];
        end
    end

    assign w_cap_bit = r_cap;
    assign w_upd_bit = r_upd;
    // The START write carries its own CAP bit, so the branch into CAPT
    // uses the bus value rather than the not-yet-updated register.
    assign w_cap_go  = apb.pwdata[1];
`else
    assign w_cap_bit = 1'b0;
    assign w_upd_bit = 1'b0;
    assign w_cap_go  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Shift datapath: only buf[LEN-1:0] moves; scan_in enters at LEN-1.
    // ------------------------------------------------------------------
    assign w_buf_rsh = r_buf >> 1;

    always_comb begin
        w_buf_shift = r_buf;
        for (int i = 0; i < c_BUF_BITS; i++) begin
            if (i < int'(r_len) - 1) begin
                w_buf_shift[i] = w_buf_rsh[i];
            end else if (i == int'(r_len) - 1) begin
                w_buf_shift[i] = scan_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, counters and next-cycle output values
    // ------------------------------------------------------------------
    assign w_phase_last = (r_div_cnt == r_div);
    assign w_last_bit   = ((int'(r_bit_cnt) + 1) == int'(r_len));

    always_comb begin
        w_state_nxt   = r_state;
        w_capt_hi_nxt = r_capt_hi;
        w_div_cnt_nxt = r_div_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_load_out    = 1'b0;
        w_shift       = 1'b0;
        w_run_end     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_div_cnt_nxt = 8'd0;
                    w_bit_cnt_nxt = '0;
                    w_capt_hi_nxt = 1'b0;
                    if (w_cap_go) begin
                        w_state_nxt = S_CAPT;
                    end else begin
                        w_state_nxt = S_LO;
                        w_load_out  = 1'b1;
                    end
                end
            end
            S_CAPT: begin
                if (w_phase_last) begin
                    w_div_cnt_nxt = 8'd0;
                    if (!r_capt_hi) begin
                        w_capt_hi_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_LO;
                        w_load_out  = 1'b1;
                    end
                end else begin
                    w_div_cnt_nxt = r_div_cnt + 8'd1;
                end
            end
            S_LO: begin
                if (w_phase_last) begin
                    // Sample scan_in one clk before scan_clk rises.
                    w_shift       = 1'b1;
                    w_div_cnt_nxt = 8'd0;
                    w_state_nxt   = S_HI;
                end else begin
                    w_div_cnt_nxt = r_div_cnt + 8'd1;
                end
            end
            S_HI: begin
                if (w_phase_last) begin
                    w_div_cnt_nxt = 8'd0;
                    w_bit_cnt_nxt = r_bit_cnt + c_BCW'(1);
                    if (w_last_bit) begin
                        if (w_upd_bit) begin
                            w_state_nxt = S_UPD;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_run_end   = 1'b1;
                        end
                    end else begin
                        // Buffer already shifted, so buf[0] is the next bit.
                        w_state_nxt = S_LO;
                        w_load_out  = 1'b1;
                    end
                end else begin
                    w_div_cnt_nxt = r_div_cnt + 8'd1;
                end
            end
            S_UPD: begin
                if (w_phase_last) begin
                    w_div_cnt_nxt = 8'd0;
                    w_state_nxt   = S_IDLE;
                    w_run_end     = 1'b1;
                end else begin
                    w_div_cnt_nxt = r_div_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they change on
        // the same edge as the state and never glitch.
        w_scan_clk_nxt = (w_state_nxt == S_HI) ||
                         ((w_state_nxt == S_CAPT) && w_capt_hi_nxt);
        w_scan_en_nxt  = (w_state_nxt == S_LO) || (w_state_nxt == S_HI);
`ifdef SCAN_STROBE_EN
        w_scan_cap_nxt = (w_state_nxt == S_CAPT);
        w_scan_upd_nxt = (w_state_nxt == S_UPD);
`else
        w_scan_cap_nxt = 1'b0;
        w_scan_upd_nxt = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_state    <= S_IDLE;
            r_capt_hi  <= 1'b0;
            r_div_cnt  <= 8'd0;
            r_bit_cnt  <= '0;
            r_scan_clk <= 1'b0;
            r_scan_en  <= 1'b0;
            r_scan_out <= 1'b0;
            r_scan_cap <= 1'b0;
            r_scan_upd <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_capt_hi  <= w_capt_hi_nxt;
            r_div_cnt  <= w_div_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_scan_clk <= w_scan_clk_nxt;
            r_scan_en  <= w_scan_en_nxt;
            r_scan_cap <= w_scan_cap_nxt;
            r_scan_upd <= w_scan_upd_nxt;
            if (w_load_out) begin
                r_scan_out <= r_buf[0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file and shift buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_len  <= 8'd8;
            r_div  <= 8'd0;
            r_buf  <= '0;
        end else begin
            if (w_start_ok) begin
                r_busy <= 1'b1;
            end else if (w_run_end) begin
                r_busy <= 1'b0;
            end

            // Completion beats a same-cycle write-1-to-clear.
            if (w_run_end) begin
                r_done <= 1'b1;
            end else if (w_start_ok || (w_wr_stat && apb.pwdata[1])) begin
                r_done <= 1'b0;
            end

            if (w_start_err) begin
                r_err <= 1'b1;
            end else if (w_start_ok || (w_wr_stat && apb.pwdata[2])) begin
                r_err <= 1'b0;
            end

            if (w_wr_len && !r_busy) begin
                r_len <= apb.pwdata;
            end
            if (w_wr_div && !r_busy) begin
                r_div <= apb.pwdata;
            end

            // Shifting only happens while busy, when data writes are locked.
            if (w_shift) begin
                r_buf <= w_buf_shift;
            end else if (w_wr && !r_busy) begin
                for (int i = 0; i < BUF_BYTES; i++) begin
                    if (w_data_hit[i]) begin
                        r_buf[8*i +: 8] <= apb.pwdata;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux (zero-wait, combinational, 0 when not selected)
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        if (apb.psel) begin
            case (apb.paddr)
                c_ADDR_CTRL: w_rdata = {5'b0, w_upd_bit, w_cap_bit, 1'b0};
                c_ADDR_STAT: w_rdata = {5'b0, r_err, r_done, r_busy};
                c_ADDR_LEN:  w_rdata = r_len;
                c_ADDR_DIV:  w_rdata = r_div;
                default: begin
                    for (int i = 0; i < BUF_BYTES; i++) begin
                        if (w_data_hit[i]) begin
                            w_rdata = r_buf[8*i +: 8];
                        end
                    end
                end
            endcase
        end
    end

    assign apb.prdata   = w_rdata;
    assign apb.pready   = 1'b1;

    assign scan_clk     = r_scan_clk;
    assign scan_enable  = r_scan_en;
    assign scan_out     = r_scan_out;
    assign scan_capture = r_scan_cap;
    assign scan_update  = r_scan_upd;

endmodule
`default_nettype wire

// File: tb/tb_apb_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_scan_ctrl
//  Purpose  : Directed self-checking bench for apb_scan_ctrl. Drives APB
//             reads/writes, models a loop-back chain, counts scan_clk edges
//             and strobe cycles, and compares against hand-computed values.
//  Options  : SCAN_STROBE_EN selects strobe-enabled expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_scan_ctrl;

    logic clk     = 1'b0;
    logic reset_b = 1'b0;
    logic scan_clk;
    logic scan_enable;
    logic scan_out;
    logic scan_in;
    logic scan_capture;
    logic scan_update;

    int n_tests = 0;
    int n_fail  = 0;

    apb_scan_if #(.PADDR_WL(8), .PDATA_WL(8)) apb ();

    apb_scan_ctrl #(
        .PADDR_WL (8),
        .PDATA_WL (8),
        .BUF_BYTES(4)
    ) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .apb         (apb),
        .scan_clk    (scan_clk),
        .scan_enable (scan_enable),
        .scan_out    (scan_out),
        .scan_in     (scan_in),
        .scan_capture(scan_capture),
        .scan_update (scan_update)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Chain model and monitors
    // ------------------------------------------------------------------
    int          sclk_rises  = 0;
    int          cap_pulses  = 0;
    time         t_rise_prev = 0;
    time         t_rise_last = 0;
    logic [7:0]  obs         = 8'h00;
    int          cap_cyc     = 0;
    int          upd_cyc     = 0;
    int          en_cyc      = 0;

    // Loop-back: the chain initially holds chain_init, so the k-th bit
    // returned on scan_in is chain_init[k] (valid for the first 8 bits).
    logic        loop_mode     = 1'b0;
    logic        scan_in_const = 1'b0;
    logic [7:0]  chain_init    = 8'h00;
    int          rise_base     = 0;
    int          loop_k;

    assign loop_k  = sclk_rises - rise_base;
    assign scan_in = loop_mode ? chain_init[loop_k[2:0]] : scan_in_const;

    always @(posedge scan_clk) begin
        sclk_rises  <= sclk_rises + 1;
        obs         <= {scan_out, obs[7:1]};
        t_rise_prev <= t_rise_last;
        t_rise_last <= $time;
        if (scan_capture) cap_pulses <= cap_pulses + 1;
    end

    always @(negedge clk) begin
        if (scan_capture) cap_cyc <= cap_cyc + 1;
        if (scan_update)  upd_cyc <= upd_cyc + 1;
        if (scan_enable)  en_cyc  <= en_cyc + 1;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [7:0] d);
        apb.psel    = 1'b1;
        apb.pwrite  = 1'b1;
        apb.penable = 1'b0;
        apb.paddr   = a;
        apb.pwdata  = d;
        tick(1);
        apb.penable = 1'b1;
        tick(1);
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [7:0] d);
        apb.psel    = 1'b1;
        apb.pwrite  = 1'b0;
        apb.penable = 1'b0;
        apb.paddr   = a;
        #1;
        d           = apb.prdata;
        apb.psel    = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int busy_cyc);
        logic [7:0] s;
        logic       idle;
        busy_cyc = 0;
        idle     = 1'b0;
        s        = 8'h00;
        for (int i = 0; i < limit && !idle; i++) begin
            apb_rd(8'h01, s);
            if (!s[0]) idle = 1'b1;
            else begin
                busy_cyc++;
                tick(1);
            end
        end
        if (!idle) check("wait_idle_timeout", {31'b0, s[0]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] rd;
        int         bc;
        int         r0, c0, u0, e0, p0;

        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        apb.paddr = 8'h00; apb.pwdata = 8'h00;

        // ---- Reset values ----
        tick(3);
        check("rst_scan_clk", scan_clk, 0);
        check("rst_pready", apb.pready, 1);
        check("rst_scan_outs", {scan_enable, scan_out, scan_capture, scan_update}, 0);
        reset_b = 1'b1;
        tick(1);
        check("prdata_unselected", apb.prdata, 0);
        apb_rd(8'h01, rd); check("rst_status", rd, 8'h00);
        apb_rd(8'h02, rd); check("rst_len", rd, 8'h08);
        apb_rd(8'h03, rd); check("rst_div", rd, 8'h00);
        apb_rd(8'h00, rd); check("rst_ctrl", rd, 8'h00);
        apb_rd(8'h10, rd); check("rst_data0", rd, 8'h00);

        // ---- LEN=8, DIV=0, loop-back with chain 0x3C ----
        apb_wr(8'h10, 8'hA5);
        apb_wr(8'h02, 8'd8);
        apb_wr(8'h03, 8'd0);
        chain_init = 8'h3C;
        rise_base  = sclk_rises;
        loop_mode  = 1'b1;
        r0         = sclk_rises;
        apb_wr(8'h00, 8'h01);
        check("t2_first_lo", {scan_enable, scan_clk, scan_out}, 3'b101);
        wait_idle(200, bc);
        check("t2_busy_cycles", bc, 16);
        check("t2_scan_out_seq", obs, 8'hA5);
        check("t2_pulses", sclk_rises - r0, 8);
        apb_rd(8'h01, rd); check("t2_status", rd, 8'h02);
        apb_rd(8'h10, rd); check("t2_data0", rd, 8'h3C);
        check("t2_pready", apb.pready, 1);
        loop_mode = 1'b0;

        // ---- LEN=3, DIV=2, scan_in=1 ----
        apb_wr(8'h01, 8'h02);
        apb_rd(8'h01, rd); check("t3_done_clr", rd, 8'h00);
        apb_wr(8'h02, 8'd3);
        apb_wr(8'h03, 8'd2);
        apb_wr(8'h10, 8'hF8);
        scan_in_const = 1'b1;
        r0 = sclk_rises;
        apb_wr(8'h00, 8'h01);
        wait_idle(200, bc);
        check("t3_busy_cycles", bc, 18);
        check("t3_pulses", sclk_rises - r0, 3);
        check("t3_sclk_period", 32'(t_rise_last - t_rise_prev), 60);
        check("t3_bits_out", obs[7:5], 3'b000);
        apb_rd(8'h10, rd); check("t3_data0", rd, 8'hFF);
        apb_rd(8'h01, rd); check("t3_status", rd, 8'h02);

        // ---- Invalid lengths ----
        apb_wr(8'h01, 8'h02);
        apb_wr(8'h02, 8'd0);
        r0 = sclk_rises;
        apb_wr(8'h00, 8'h01);
        tick(4);
        apb_rd(8'h01, rd); check("t4_len0_err", rd, 8'h04);
        check("t4_len0_no_sclk", sclk_rises - r0, 0);
        apb_wr(8'h01, 8'h04);
        apb_rd(8'h01, rd); check("t4_err_clr", rd, 8'h00);
        apb_wr(8'h02, 8'd33);
        apb_wr(8'h00, 8'h01);
        tick(4);
        apb_rd(8'h01, rd); check("t4_len33_err", rd, 8'h04);
        check("t4_len33_no_sclk", sclk_rises - r0, 0);
        apb_wr(8'h01, 8'h04);
        apb_rd(8'h01, rd); check("t4_err_clr2", rd, 8'h00);

        // ---- Strobes: CAP=UPD=1, LEN=4, DIV=1 ----
        apb_wr(8'h02, 8'd4);
        apb_wr(8'h03, 8'd1);
        r0 = sclk_rises; c0 = cap_cyc; u0 = upd_cyc; e0 = en_cyc; p0 = cap_pulses;
        apb_wr(8'h00, 8'h07);
        wait_idle(200, bc);
        tick(1);
        check("t5_shift_cycles", en_cyc - e0, 16);
`ifdef SCAN_STROBE_EN
        check("t5_busy_cycles", bc, 22);
        check("t5_cap_cycles", cap_cyc - c0, 4);
        check("t5_cap_pulses", cap_pulses - p0, 1);
        check("t5_upd_cycles", upd_cyc - u0, 2);
        check("t5_pulses", sclk_rises - r0, 5);
        apb_rd(8'h00, rd); check("t5_ctrl", rd, 8'h06);
`else
        check("t5_busy_cycles", bc, 16);
        check("t5_cap_cycles", cap_cyc - c0, 0);
        check("t5_upd_cycles", upd_cyc - u0, 0);
        check("t5_pulses", sclk_rises - r0, 4);
        apb_rd(8'h00, rd); check("t5_ctrl", rd, 8'h00);
`endif

        // ---- Mid-shift writes ignored, then reset mid-run ----
        apb_wr(8'h01, 8'h06);
        apb_wr(8'h02, 8'd8);
        apb_wr(8'h03, 8'd3);
        apb_wr(8'h10, 8'hFF);
        scan_in_const = 1'b1;
        apb_wr(8'h00, 8'h01);
        tick(10);
        apb_wr(8'h00, 8'h01);
        apb_wr(8'h10, 8'h00);
        apb_wr(8'h02, 8'd5);
        apb_rd(8'h01, rd); check("t6_busy_no_err", rd, 8'h01);
        apb_rd(8'h02, rd); check("t6_len_locked", rd, 8'h08);
        apb_rd(8'h10, rd); check("t6_data_locked", rd, 8'hFF);
        for (int i = 0; i < 40 && !scan_clk; i++) tick(1);
        check("t6_pre_rst_outs", {scan_clk, scan_enable, scan_out}, 3'b111);
        reset_b = 1'b0;
        tick(1);
        check("t6_rst_outs", {scan_clk, scan_enable, scan_out, scan_capture, scan_update}, 0);
        apb_rd(8'h01, rd); check("t6_rst_status", rd, 8'h00);
        apb_rd(8'h10, rd); check("t6_rst_data0", rd, 8'h00);
        reset_b = 1'b1;
        tick(1);
        apb_rd(8'h02, rd); check("t6_rst_len", rd, 8'h08);
        check("t6_pready", apb.pready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
